// File: rtl/stats_pkg.sv
// stats_pkg: widths, the stat-entry struct and the output-register state shared by the stats arbiter files.
package stats_pkg;
    localparam int DEF_INC_W = 16;
    localparam int DEF_ID_W  = 8;
    function automatic int port_sel_w(int ports);
        return ports > 1 ? $clog2(ports) : 1;
    endfunction
    function automatic int m_id_w(int ports, int id_w);
        return id_w + port_sel_w(ports);
    endfunction
    typedef struct packed {
        logic [DEF_INC_W-1:0] tdata;
        logic [DEF_ID_W-1:0]  tid;
    } stat_entry_t;
    typedef enum logic {EMPTY, FULL} out_state_e;
endpackage

// File: rtl/stats_arb_if.sv
// stats_arb_if: merged-stream bus; slave is the arbiter's view, master the collectors' and sink's view.
interface stats_arb_if import stats_pkg::*; #(
    parameter int PORTS          = 4,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = 8,
    parameter int M_ID_WIDTH     = m_id_w(PORTS, STAT_ID_WIDTH)
);
    logic [PORTS*STAT_INC_WIDTH-1:0] s_axis_stat_tdata;
    logic [PORTS*STAT_ID_WIDTH-1:0]  s_axis_stat_tid;
    logic [PORTS-1:0]                s_axis_stat_tvalid;
    logic [PORTS-1:0]                s_axis_stat_tready;
    logic [STAT_INC_WIDTH-1:0]       m_axis_stat_tdata;
    logic [M_ID_WIDTH-1:0]           m_axis_stat_tid;
    logic                            m_axis_stat_tvalid;
    logic                            m_axis_stat_tready;
    modport slave (
        input  s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid, m_axis_stat_tready,
        output s_axis_stat_tready, m_axis_stat_tdata, m_axis_stat_tid, m_axis_stat_tvalid
    );
    modport master (
        output s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid, m_axis_stat_tready,
        input  s_axis_stat_tready, m_axis_stat_tdata, m_axis_stat_tid, m_axis_stat_tvalid
    );
endinterface

// File: rtl/stats_rr_select.sv
// stats_rr_select: combinational round-robin selector after i_last; fixed lowest-index priority
// when STATS_ARB_PRIO_EN is defined (i_last then ignored).
module stats_rr_select #(
    parameter int PORTS = 4,
    parameter int SEL_W = 2
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);
    assign o_any = |i_req;
`ifdef STATS_ARB_PRIO_EN
    always_comb begin
        o_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--)
            if (i_req[i]) o_idx = SEL_W'(i);
    end
`else
    always_comb begin
        o_idx = '0;
        // walk backwards so the candidate closest after i_last is written last and wins
        for (int i = PORTS; i >= 1; i--)
            if (i_req[(int'(i_last) + i) % PORTS]) o_idx = SEL_W'((int'(i_last) + i) % PORTS);
    end
`endif
endmodule

// File: rtl/stats_arb.sv
// stats_arb: merges per-port stat increments through one-entry holds and a round-robin output register.
// Define STATS_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module stats_arb import stats_pkg::*; #(
    parameter int PORTS          = 4,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = 8,
    parameter int PORT_SEL_WIDTH = port_sel_w(PORTS),
    parameter int M_ID_WIDTH     = STAT_ID_WIDTH + PORT_SEL_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    stats_arb_if.slave s,
    output logic       busy
);
    logic [PORTS-1:0]          r_hold_v;
    logic [STAT_INC_WIDTH-1:0] r_hold_d [PORTS];
    logic [STAT_ID_WIDTH-1:0]  r_hold_id [PORTS];
    logic [PORT_SEL_WIDTH-1:0] w_idx, w_last;
    logic                      w_any, w_grant;
    out_state_e                r_state, w_state_nxt;
    logic [STAT_INC_WIDTH-1:0] r_m_tdata;
    logic [M_ID_WIDTH-1:0]     r_m_tid;

    stats_rr_select #(.PORTS(PORTS), .SEL_W(PORT_SEL_WIDTH)) u_sel (
        .i_req(r_hold_v), .i_last(w_last), .o_idx(w_idx), .o_any(w_any)
    );

    assign w_grant              = w_any && (r_state == EMPTY || s.m_axis_stat_tready);
    assign s.s_axis_stat_tready = ~r_hold_v;
    assign s.m_axis_stat_tvalid = r_state == FULL;
    assign s.m_axis_stat_tdata  = r_m_tdata;
    assign s.m_axis_stat_tid    = r_m_tid;
    assign busy                 = |r_hold_v || r_state == FULL;

    // zero increments are accepted but never stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v <= '0;
            for (int n = 0; n < PORTS; n++) begin
                r_hold_d[n]  <= '0;
                r_hold_id[n] <= '0;
            end
        end else begin
            for (int n = 0; n < PORTS; n++) begin
                if (w_grant && w_idx == PORT_SEL_WIDTH'(n)) begin
                    r_hold_v[n] <= 1'b0;
                end else if (s.s_axis_stat_tvalid[n] && !r_hold_v[n] &&
                             s.s_axis_stat_tdata[n*STAT_INC_WIDTH +: STAT_INC_WIDTH] != '0) begin
                    r_hold_v[n]  <= 1'b1;
                    r_hold_d[n]  <= s.s_axis_stat_tdata[n*STAT_INC_WIDTH +: STAT_INC_WIDTH];
                    r_hold_id[n] <= s.s_axis_stat_tid[n*STAT_ID_WIDTH +: STAT_ID_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tdata <= '0;
            r_m_tid   <= '0;
        end else if (w_grant) begin
            r_m_tdata <= r_hold_d[w_idx];
            r_m_tid   <= {w_idx, r_hold_id[w_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_grant ? FULL : (s.m_axis_stat_tready ? EMPTY : r_state);
    end

`ifdef STATS_ARB_PRIO_EN
    assign w_last = '0;
`else
    logic [PORT_SEL_WIDTH-1:0] r_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_last <= PORT_SEL_WIDTH'(PORTS - 1);
        else if (w_grant) r_last <= w_idx;
    end
    assign w_last = r_last;
`endif
endmodule

// File: tb/tb_stats_arb.sv
// tb_stats_arb: directed scenarios plus a random soak scored against a per-port queue/sum model.
module tb_stats_arb;
    import stats_pkg::*;
    localparam int P = 4, W = 16, I = 8, M = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_cmp = 0, n_err = 0;

    int          port_q[$];
    stat_entry_t ent_q[$];
    longint      sum_in [P*256];
    longint      sum_out[P*256];

    stats_arb_if #(.PORTS(P), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(I), .M_ID_WIDTH(M)) bus ();
    stats_arb #(.PORTS(P), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(I)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus.slave), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic [W-1:0] d, input logic [I-1:0] id);
        bus.s_axis_stat_tvalid[n]      = v;
        bus.s_axis_stat_tdata[n*W +: W] = d;
        bus.s_axis_stat_tid[n*I +: I]   = id;
    endtask

    task automatic idle_in;
        for (int n = 0; n < P; n++) drive(n, 1'b0, '0, '0);
    endtask

    task automatic record_out;
        int p, idx;
        if (bus.m_axis_stat_tvalid && bus.m_axis_stat_tready) begin
            p   = int'(bus.m_axis_stat_tid[M-1:I]);
            idx = -1;
            for (int i = 0; i < port_q.size(); i++)
                if (idx < 0 && port_q[i] == p) idx = i;
            n_cmp++;
            if (idx < 0) begin
                n_err++;
                $display("FAIL soak_unexpected: got port %0d tid %h data %h, expected a queued entry", p,
                         bus.m_axis_stat_tid, bus.m_axis_stat_tdata);
            end else begin
                if (ent_q[idx] !== {bus.m_axis_stat_tdata, bus.m_axis_stat_tid[I-1:0]}) begin
                    n_err++;
                    $display("FAIL soak_order: port %0d got %h expected %h", p,
                             {bus.m_axis_stat_tdata, bus.m_axis_stat_tid[I-1:0]}, ent_q[idx]);
                end
                port_q.delete(idx);
                ent_q.delete(idx);
            end
            sum_out[p*256 + int'(bus.m_axis_stat_tid[I-1:0])] += longint'(bus.m_axis_stat_tdata);
        end
    endtask

    task automatic test_reset;
        idle_in();
        bus.m_axis_stat_tready = 1'b1;
        cyc();
        cyc();
        n_cmp += 5;
        if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b exp 0", bus.m_axis_stat_tvalid); end
        if (bus.m_axis_stat_tdata !== '0) begin n_err++; $display("FAIL reset_tdata got %h exp 0", bus.m_axis_stat_tdata); end
        if (bus.m_axis_stat_tid !== '0) begin n_err++; $display("FAIL reset_tid got %h exp 0", bus.m_axis_stat_tid); end
        if (bus.s_axis_stat_tready !== 4'hf) begin n_err++; $display("FAIL reset_tready got %b exp 1111", bus.s_axis_stat_tready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        drive(2, 1'b1, 16'd5, 8'd3);
        cyc();
        idle_in();
        n_cmp += 2;
        if (bus.s_axis_stat_tready[2] !== 1'b0) begin n_err++; $display("FAIL single_tready_low got %b exp 0", bus.s_axis_stat_tready[2]); end
        if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL single_early got %b exp 0", bus.m_axis_stat_tvalid); end
        cyc();
        n_cmp += 4;
        if (bus.m_axis_stat_tvalid !== 1'b1) begin n_err++; $display("FAIL single_tvalid got %b exp 1", bus.m_axis_stat_tvalid); end
        if (bus.m_axis_stat_tdata !== 16'd5) begin n_err++; $display("FAIL single_tdata got %h exp 5", bus.m_axis_stat_tdata); end
        if (bus.m_axis_stat_tid !== 10'h203) begin n_err++; $display("FAIL single_tid got %h exp 203", bus.m_axis_stat_tid); end
        if (bus.s_axis_stat_tready[2] !== 1'b1) begin n_err++; $display("FAIL single_tready_back got %b exp 1", bus.s_axis_stat_tready[2]); end
        cyc();
        n_cmp += 2;
        if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b exp 0", bus.m_axis_stat_tvalid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_drop;
        drive(0, 1'b1, '0, 8'h44);
        cyc();
        idle_in();
        n_cmp += 2;
        if (bus.s_axis_stat_tready[0] !== 1'b1) begin n_err++; $display("FAIL zero_tready got %b exp 1", bus.s_axis_stat_tready[0]); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b exp 0", busy); end
        cyc();
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_output got tvalid %b busy %b exp 0 0", bus.m_axis_stat_tvalid, busy);
        end
    endtask

    task automatic test_round_robin;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int n = 0; n < P; n++) drive(n, 1'b1, W'(16'h100 + n), I'(n * 17));
        cyc();
        idle_in();
        for (int k = 0; k < P; k++) begin
            cyc();
            n_cmp++;
            if (bus.m_axis_stat_tvalid !== 1'b1 || bus.m_axis_stat_tid !== M'({2'(k), 8'(k * 17)}) ||
                bus.m_axis_stat_tdata !== W'(16'h100 + k)) begin
                n_err++;
                $display("FAIL rr_order slot %0d got v%b tid %h data %h exp port %0d", k,
                         bus.m_axis_stat_tvalid, bus.m_axis_stat_tid, bus.m_axis_stat_tdata, k);
            end
        end
        cyc();
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL rr_end got %b exp 0", bus.m_axis_stat_tvalid); end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] d0;
        logic [M-1:0] t0;
        bus.m_axis_stat_tready = 1'b0;
        drive(1, 1'b1, 16'hAAAA, 8'h11);
        drive(3, 1'b1, 16'h5555, 8'h33);
        cyc();
        idle_in();
        cyc();
        d0 = bus.m_axis_stat_tdata;
        t0 = bus.m_axis_stat_tid;
        n_cmp++;
        if (t0 !== 10'h111 || d0 !== 16'hAAAA) begin n_err++; $display("FAIL bp_first got tid %h data %h exp 111 aaaa", t0, d0); end
        for (int c = 0; c < 10; c++) begin
            cyc();
            n_cmp++;
            if (bus.m_axis_stat_tvalid !== 1'b1 || bus.m_axis_stat_tdata !== d0 || bus.m_axis_stat_tid !== t0 ||
                bus.s_axis_stat_tready[3] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got v%b tid %h data %h rdy3 %b exp v1 tid %h data %h rdy3 0", c,
                         bus.m_axis_stat_tvalid, bus.m_axis_stat_tid, bus.m_axis_stat_tdata, bus.s_axis_stat_tready[3], t0, d0);
            end
        end
        bus.m_axis_stat_tready = 1'b1;
        cyc();
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b1 || bus.m_axis_stat_tid !== 10'h333 || bus.m_axis_stat_tdata !== 16'h5555) begin
            n_err++; $display("FAIL bp_second got v%b tid %h data %h exp v1 333 5555", bus.m_axis_stat_tvalid, bus.m_axis_stat_tid, bus.m_axis_stat_tdata);
        end
        cyc();
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_end got %b exp 0", bus.m_axis_stat_tvalid); end
    endtask

    task automatic test_reset_mid;
        bus.m_axis_stat_tready = 1'b0;
        for (int n = 0; n < P; n++) drive(n, 1'b1, W'(n + 7), I'(n));
        cyc();
        idle_in();
        cyc();
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b1 || bus.s_axis_stat_tready !== 4'b0001) begin
            n_err++; $display("FAIL rmid_setup got v%b rdy %b exp v1 rdy 0001", bus.m_axis_stat_tvalid, bus.s_axis_stat_tready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_axis_stat_tvalid !== 1'b0 || bus.s_axis_stat_tready !== 4'hf || busy !== 1'b0) begin
            n_err++; $display("FAIL rmid_async got v%b rdy %b busy %b exp 0 1111 0", bus.m_axis_stat_tvalid, bus.s_axis_stat_tready, busy);
        end
        cyc();
        rst_n = 1'b1;
        bus.m_axis_stat_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_cmp++;
            if (bus.m_axis_stat_tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_leak cycle %0d got tvalid %b exp 0", c, bus.m_axis_stat_tvalid); end
        end
    endtask

    task automatic test_soak;
        logic         held;
        logic [W-1:0] hd;
        logic [M-1:0] ht;
        logic [W-1:0] d;
        logic [I-1:0] id;
        int           drained;
        held = 1'b0;
        hd = '0;
        ht = '0;
        for (int i = 0; i < P*256; i++) begin sum_in[i] = 0; sum_out[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            if (held) begin
                n_cmp++;
                if (bus.m_axis_stat_tvalid !== 1'b1 || bus.m_axis_stat_tdata !== hd || bus.m_axis_stat_tid !== ht) begin
                    n_err++; $display("FAIL soak_stable cycle %0d got v%b %h/%h exp v1 %h/%h", c,
                                      bus.m_axis_stat_tvalid, bus.m_axis_stat_tid, bus.m_axis_stat_tdata, ht, hd);
                end
            end
            for (int n = 0; n < P; n++) begin
                d  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                id = I'($urandom);
                drive(n, 1'($urandom_range(0, 1)), d, id);
                if (bus.s_axis_stat_tvalid[n] && bus.s_axis_stat_tready[n] && d != '0) begin
                    port_q.push_back(n);
                    ent_q.push_back('{tdata: d, tid: id});
                    sum_in[n*256 + int'(id)] += longint'(d);
                end
            end
            bus.m_axis_stat_tready = ($urandom_range(0, 3) != 0);
            record_out();
            held = bus.m_axis_stat_tvalid && !bus.m_axis_stat_tready;
            hd = bus.m_axis_stat_tdata;
            ht = bus.m_axis_stat_tid;
            cyc();
        end
        idle_in();
        bus.m_axis_stat_tready = 1'b1;
        drained = 0;
        for (int c = 0; c < 50 && !drained; c++) begin
            record_out();
            cyc();
            if (!busy && !bus.m_axis_stat_tvalid) drained = 1;
        end
        n_cmp++;
        if (!drained) begin n_err++; $display("FAIL soak_drain_timeout busy %b exp 0 within 50 cycles", busy); end
        n_cmp++;
        if (port_q.size() != 0) begin n_err++; $display("FAIL soak_lost got %0d entries left exp 0", port_q.size()); end
        for (int i = 0; i < P*256; i++) begin
            n_cmp++;
            if (sum_out[i] != sum_in[i]) begin
                n_err++; $display("FAIL soak_sum port %0d tid %0d got %0d exp %0d", i / 256, i % 256, sum_out[i], sum_in[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_drop();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
